inst_sequencer: RTL and testbench
=================================

INST_SEQUENCER -- requirements
Module: inst_sequencer

Interface
REQ-001 Parameter FIFO_DEPTH, default 16, instruction queue entries; the value SHALL be a power of 2 and at least 2.
REQ-002 Parameter REP_BITS, default 8, width of the per-entry repeat count.
REQ-003 Port clk  in  1  sole clock; all state SHALL update on the rising edge.
REQ-004 Port reset  in  1  reset, synchronous and active-high.
REQ-005 Port push_valid  in  1  host offers one queue entry.
REQ-006 Port push_inst  in  INST_BITS  instruction; opcode, addra and addrb fields as defined in sa_share.
REQ-007 Port push_rep  in  REP_BITS  extra issues of this entry (0 = issue once).
REQ-008 Port push_ready  out  1  queue can accept an entry.
REQ-009 Port start  in  1  single-cycle request to begin issuing.
REQ-010 Port abort  in  1  single-cycle request to flush and stop.
REQ-011 Port cu_flag  in  1  control-unit flag; high means the CU loads its instruction input at this edge.
REQ-012 Port cu_inst  out  INST_BITS  instruction presented to the control unit.
REQ-013 Port busy  out  1  high while in RUN.
REQ-014 Port done  out  1  one-cycle pulse at program completion.
REQ-015 Port fifo_count  out  $clog2(FIFO_DEPTH)+1  current number of queued entries.

Function
REQ-016 The block SHALL store entries {inst, rep} in a synchronous FIFO; a push occurs when push_valid && push_ready.
REQ-017 push_ready SHALL equal (fifo_count < FIFO_DEPTH); a same-cycle pop SHALL NOT raise push_ready when the FIFO is full.
REQ-018 The block SHALL implement two states: IDLE and RUN.
REQ-019 In IDLE, cu_inst SHALL equal IDLE_INST, and start SHALL move the block to RUN on the next edge.
REQ-020 In RUN with fifo_count > 0, cu_inst SHALL be combinational from the head entry: opcode unchanged; addra = head.addra + rep_idx and addrb = head.addrb + rep_idx, each truncated to its field width (wrap-around).
REQ-021 In RUN with fifo_count = 0, cu_inst SHALL equal IDLE_INST.
REQ-022 An issue SHALL occur when state = RUN, fifo_count > 0 and cu_flag = 1.
REQ-023 On an issue with rep_idx = head.rep, the block SHALL pop the head and clear rep_idx to 0; otherwise it SHALL increment rep_idx.
REQ-024 In RUN with fifo_count = 0 and cu_flag = 1, the block SHALL pulse done for one cycle and return to IDLE, because the CU has then finished its last issued instruction.
REQ-025 A push and a pop in the same cycle SHALL leave fifo_count unchanged, and pushes SHALL be accepted in both IDLE and RUN.
REQ-026 start SHALL be ignored while in RUN.
REQ-027 abort SHALL have highest priority: on the next edge the FIFO empties, rep_idx = 0, state = IDLE, and no done pulse is generated.
REQ-028 A push or start in the same cycle as abort SHALL be discarded.
REQ-029 With cu_flag held high, issue latency SHALL be zero cycles: the entry is consumed at the edge where cu_flag is sampled high.
REQ-030 Consecutive issues SHALL occur on consecutive cycles whenever cu_flag stays high.

Reset
REQ-031 Reset SHALL take priority over all other inputs.
REQ-032 At the edge where reset = 1, state SHALL become IDLE, the FIFO pointers and count SHALL become 0, and rep_idx SHALL become 0.
REQ-033 After reset, outputs SHALL be: cu_inst = IDLE_INST, push_ready = 1, busy = 0, done = 0, fifo_count = 0.

Structure
REQ-034 INST_BITS, the opcode/addra/addrb field ranges and IDLE_INST SHALL come from sa_share.
REQ-035 SEQ_FIFO_DEPTH and REP_BITS defaults SHALL be added to sa_share.
REQ-036 The FIFO SHALL be one sub-module, inst_fifo, parameterised by width (INST_BITS+REP_BITS) and depth, with show-ahead head output and a count output.

Verification
REQ-037 Push {addra=5, addrb=9, rep=2}, start, cu_flag=1 -> cu_inst addra 5,6,7 / addrb 9,10,11 on three consecutive cycles, then done pulses once and busy falls.
REQ-038 Push addra = field max with rep=1 -> second issue has addra=0 (wrap-around).
REQ-039 Fill 16 entries -> push_ready=0 and fifo_count=16; a 17th push is dropped; push+pop while full -> count 15, not 16.
REQ-040 cu_flag low for 5 cycles mid-RUN -> cu_inst holds steady and rep_idx and fifo_count are unchanged.
REQ-041 abort with 4 entries queued in RUN -> next cycle fifo_count=0, cu_inst=IDLE_INST, busy=0, and done never pulses.
REQ-042 Reset asserted mid-RUN with start also high -> all outputs at reset values next cycle and state IDLE.

Source files
------------

// File: rtl/sa_share.sv
// Shared definitions for the systolic-array control path.
// Holds the instruction word layout, the idle instruction, the sequencer
// defaults and a helper that offsets the two address fields of an instruction.
package sa_share;

    // Instruction layout: {opcode[15:12], addra[11:6], addrb[5:0]}
    localparam int unsigned OPCODE_BITS = 4;
    localparam int unsigned ADDR_BITS   = 6;
    localparam int unsigned INST_BITS   = OPCODE_BITS + 2 * ADDR_BITS;

    localparam int unsigned OPCODE_MSB = INST_BITS - 1;
    localparam int unsigned OPCODE_LSB = 2 * ADDR_BITS;
    localparam int unsigned ADDRA_MSB  = 2 * ADDR_BITS - 1;
    localparam int unsigned ADDRA_LSB  = ADDR_BITS;
    localparam int unsigned ADDRB_MSB  = ADDR_BITS - 1;
    localparam int unsigned ADDRB_LSB  = 0;

    // Opcode 0 with zero addresses is a no-op for the control unit.
    localparam logic [INST_BITS-1:0] IDLE_INST = '0;

    // Sequencer defaults
    localparam int unsigned SEQ_FIFO_DEPTH = 16;
    localparam int unsigned SEQ_REP_BITS   = 8;

    typedef enum logic [0:0] {
        StIdle,
        StRun
    } seq_state_e;

    // Adds idx to both address fields; each field wraps within its own width.
    function automatic logic [INST_BITS-1:0] offset_inst(
        input logic [INST_BITS-1:0] inst,
        input logic [ADDR_BITS-1:0] idx
    );
        logic [INST_BITS-1:0] r;
        r = inst;
        r[ADDRA_MSB:ADDRA_LSB] = inst[ADDRA_MSB:ADDRA_LSB] + idx;
        r[ADDRB_MSB:ADDRB_LSB] = inst[ADDRB_MSB:ADDRB_LSB] + idx;
        return r;
    endfunction

endpackage

// File: rtl/inst_fifo.sv
// Synchronous show-ahead FIFO for the instruction sequencer.
// Ports:
//   clk, reset   - clock and synchronous active-high reset
//   flush        - empties the FIFO at the next edge (dominates push/pop)
//   push, wdata  - write request and data; ignored when full
//   pop          - removes the head entry; ignored when empty
//   rdata        - current head entry (valid while count > 0)
//   count        - number of stored entries
module inst_fifo #(
    parameter int unsigned WIDTH = 24,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             do_push, do_pop;

    assign do_push = push && (count_q < DepthCnt);
    assign do_pop  = pop && (count_q != '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + PtrW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end
            // Simultaneous push and pop leaves the count unchanged.
            unique case ({do_push, do_pop})
                2'b10:   count_d = count_q + CntW'(1);
                2'b01:   count_d = count_q - CntW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (!reset && !flush && do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/inst_sequencer.sv
// Instruction sequencer: queues {inst, rep} entries from a host and issues
// each entry rep+1 times to the control unit, offsetting both address fields
// by the repeat index on every issue.
// Ports:
//   clk, reset                         - clock, synchronous active-high reset
//   push_valid/push_inst/push_rep      - host enqueue request
//   push_ready                         - queue has room
//   start, abort                       - begin issuing / flush and stop
//   cu_flag                            - CU loads cu_inst at this edge
//   cu_inst                            - instruction presented to the CU
//   busy, done                         - running / one-cycle completion pulse
//   fifo_count                         - queued entries
module inst_sequencer
    import sa_share::*;
#(
    parameter int unsigned FIFO_DEPTH = SEQ_FIFO_DEPTH,
    parameter int unsigned REP_BITS   = SEQ_REP_BITS
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          push_valid,
    input  logic [INST_BITS-1:0]          push_inst,
    input  logic [REP_BITS-1:0]           push_rep,
    output logic                          push_ready,
    input  logic                          start,
    input  logic                          abort,
    input  logic                          cu_flag,
    output logic [INST_BITS-1:0]          cu_inst,
    output logic                          busy,
    output logic                          done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int unsigned EntW = INST_BITS + REP_BITS;
    localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CntW-1:0] DepthCnt = CntW'(FIFO_DEPTH);

    seq_state_e           state_q, state_d;
    logic [REP_BITS-1:0]  rep_idx_q, rep_idx_d;
    logic                 done_q, done_d;

    logic [EntW-1:0]      head;
    logic [INST_BITS-1:0] head_inst;
    logic [REP_BITS-1:0]  head_rep;
    logic                 fifo_empty;
    logic                 push_fire;
    logic                 issue;
    logic                 pop;

    assign head_inst  = head[EntW-1:REP_BITS];
    assign head_rep   = head[REP_BITS-1:0];
    assign fifo_empty = (fifo_count == '0);

    // Based on the registered count only, so a same-cycle pop cannot open a
    // slot in a full FIFO.
    assign push_ready = (fifo_count < DepthCnt);
    assign push_fire  = push_valid && push_ready && !abort;

    assign issue = (state_q == StRun) && !fifo_empty && cu_flag;
    assign pop   = issue && (rep_idx_q == head_rep);

    inst_fifo #(
        .WIDTH (EntW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (abort),
        .push  (push_fire),
        .wdata ({push_inst, push_rep}),
        .pop   (pop),
        .rdata (head),
        .count (fifo_count)
    );

    always_comb begin
        state_d   = state_q;
        rep_idx_d = rep_idx_q;
        done_d    = 1'b0;
        if (abort) begin
            state_d   = StIdle;
            rep_idx_d = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_d = StRun;
                    end
                end
                StRun: begin
                    if (issue) begin
                        rep_idx_d = pop ? '0 : rep_idx_q + REP_BITS'(1);
                    end else if (fifo_empty && cu_flag) begin
                        // CU has taken the idle instruction: last issue retired.
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            rep_idx_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rep_idx_q <= rep_idx_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        cu_inst = IDLE_INST;
        if ((state_q == StRun) && !fifo_empty) begin
            cu_inst = offset_inst(head_inst, ADDR_BITS'(rep_idx_q));
        end
    end

    assign busy = (state_q == StRun);
    assign done = done_q;

endmodule

// File: tb/tb_inst_sequencer.sv
module tb_inst_sequencer;
    import sa_share::*;

    localparam int DEPTH = 16;

    logic                 clk = 1'b0;
    logic                 reset, push_valid, start, abort, cu_flag;
    logic [INST_BITS-1:0] push_inst, cu_inst;
    logic [7:0]           push_rep;
    logic                 push_ready, busy, done;
    logic [4:0]           fifo_count;

    always #5 clk = ~clk;

    inst_sequencer #(
        .FIFO_DEPTH (DEPTH),
        .REP_BITS   (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .push_valid (push_valid),
        .push_inst  (push_inst),
        .push_rep   (push_rep),
        .push_ready (push_ready),
        .start      (start),
        .abort      (abort),
        .cu_flag    (cu_flag),
        .cu_inst    (cu_inst),
        .busy       (busy),
        .done       (done),
        .fifo_count (fifo_count)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: a queue of decoded entries plus run flag and repeat index.
    typedef struct {
        int op;
        int a;
        int b;
        int rep;
    } ent_t;
    ent_t mq[$];
    bit   m_run;
    int   m_idx;
    bit   m_done;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, got, exp);
        end
    endtask

    function automatic int m_cu();
        int m;
        m = 1 << ADDR_BITS;
        if (m_run && mq.size() > 0) begin
            return (mq[0].op << OPCODE_LSB) | (((mq[0].a + m_idx) % m) << ADDRA_LSB)
                   | ((mq[0].b + m_idx) % m);
        end
        return 0;
    endfunction

    task automatic check_model(input string tag);
        check({tag, ".cu_inst"}, 32'(cu_inst), m_cu());
        check({tag, ".push_ready"}, 32'(push_ready), 32'(mq.size() < DEPTH));
        check({tag, ".busy"}, 32'(busy), 32'(m_run));
        check({tag, ".done"}, 32'(done), 32'(m_done));
        check({tag, ".fifo_count"}, 32'(fifo_count), mq.size());
    endtask

    task automatic model_edge();
        int   sz;
        bit   do_pop;
        ent_t e;
        sz     = mq.size();
        do_pop = 1'b0;
        if (reset || abort) begin
            mq.delete();
            m_run  = 1'b0;
            m_idx  = 0;
            m_done = 1'b0;
            return;
        end
        m_done = 1'b0;
        if (m_run && sz > 0 && cu_flag) begin
            if (m_idx == mq[0].rep) begin
                do_pop = 1'b1;
                m_idx  = 0;
            end else begin
                m_idx++;
            end
        end else if (m_run && sz == 0 && cu_flag) begin
            m_run  = 1'b0;
            m_done = 1'b1;
        end else if (!m_run && start) begin
            m_run = 1'b1;
        end
        if (push_valid && sz < DEPTH) begin
            e.op  = int'(push_inst[OPCODE_MSB:OPCODE_LSB]);
            e.a   = int'(push_inst[ADDRA_MSB:ADDRA_LSB]);
            e.b   = int'(push_inst[ADDRB_MSB:ADDRB_LSB]);
            e.rep = int'(push_rep);
            mq.push_back(e);
        end
        if (do_pop) void'(mq.pop_front());
    endtask

    task automatic drive(input logic pv, input logic [INST_BITS-1:0] pi, input logic [7:0] pr,
                         input logic st, input logic ab, input logic cf, input logic rs);
        @(negedge clk);
        push_valid = pv;
        push_inst  = pi;
        push_rep   = pr;
        start      = st;
        abort      = ab;
        cu_flag    = cf;
        reset      = rs;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
    endtask

    task automatic idle_drive();
        drive(1'b0, '0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        drive(1'b0, '0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
    endtask

    function automatic logic [INST_BITS-1:0] mk(input int op, input int a, input int b);
        return INST_BITS'((op << OPCODE_LSB) | (a << ADDRA_LSB) | b);
    endfunction

    typedef struct {
        logic                 pv;
        logic [INST_BITS-1:0] inst;
        logic [7:0]           rep;
        logic                 st;
        logic                 cf;
        logic [INST_BITS-1:0] e_inst;
        logic                 e_busy;
        logic                 e_done;
        int                   e_cnt;
    } vec_t;

    function automatic vec_t v(input logic pv, input logic [INST_BITS-1:0] inst,
                               input logic [7:0] rep, input logic st, input logic cf,
                               input logic [INST_BITS-1:0] e_inst, input logic e_busy,
                               input logic e_done, input int e_cnt);
        vec_t r;
        r.pv = pv; r.inst = inst; r.rep = rep; r.st = st; r.cf = cf;
        r.e_inst = e_inst; r.e_busy = e_busy; r.e_done = e_done; r.e_cnt = e_cnt;
        return r;
    endfunction

    vec_t tbl[14];
    logic [INST_BITS-1:0] saved;

    initial begin
        // Three-issue program (addr 5/9, rep 2), then a wrap-around program.
        tbl[0]  = v(1, mk(3, 5, 9), 2, 0, 0, 16'd0,       0, 0, 0);
        tbl[1]  = v(0, '0,          0, 1, 0, 16'd0,       0, 0, 1);
        tbl[2]  = v(0, '0,          0, 0, 1, mk(3, 5, 9),  1, 0, 1);
        tbl[3]  = v(0, '0,          0, 0, 1, mk(3, 6, 10), 1, 0, 1);
        tbl[4]  = v(0, '0,          0, 0, 1, mk(3, 7, 11), 1, 0, 1);
        tbl[5]  = v(0, '0,          0, 0, 1, 16'd0,       1, 0, 0);
        tbl[6]  = v(0, '0,          0, 0, 0, 16'd0,       0, 1, 0);
        tbl[7]  = v(0, '0,          0, 0, 0, 16'd0,       0, 0, 0);
        tbl[8]  = v(1, mk(1, 63, 0), 1, 0, 0, 16'd0,      0, 0, 0);
        tbl[9]  = v(0, '0,          0, 1, 0, 16'd0,       0, 0, 1);
        tbl[10] = v(0, '0,          0, 0, 1, mk(1, 63, 0), 1, 0, 1);
        tbl[11] = v(0, '0,          0, 0, 1, mk(1, 0, 1),  1, 0, 1);
        tbl[12] = v(0, '0,          0, 0, 1, 16'd0,       1, 0, 0);
        tbl[13] = v(0, '0,          0, 0, 0, 16'd0,       0, 1, 0);

        push_valid = 0; push_inst = '0; push_rep = '0;
        start = 0; abort = 0; cu_flag = 0; reset = 1;
        do_reset();
        do_reset();

        // Reset values
        idle_drive();
        check("rst.cu_inst", 32'(cu_inst), 32'(IDLE_INST));
        check("rst.push_ready", 32'(push_ready), 1);
        check("rst.busy", 32'(busy), 0);
        check("rst.done", 32'(done), 0);
        check("rst.fifo_count", 32'(fifo_count), 0);

        // Table-driven vectors
        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].pv, tbl[i].inst, tbl[i].rep, tbl[i].st, 1'b0, tbl[i].cf, 1'b0);
            check($sformatf("tbl%0d.cu_inst", i), 32'(cu_inst), 32'(tbl[i].e_inst));
            check($sformatf("tbl%0d.busy", i), 32'(busy), 32'(tbl[i].e_busy));
            check($sformatf("tbl%0d.done", i), 32'(done), 32'(tbl[i].e_done));
            check($sformatf("tbl%0d.fifo_count", i), 32'(fifo_count), tbl[i].e_cnt);
            tick();
        end

        // Fill to full, drop a 17th push, push+pop while full
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, mk(2, i, 2 * i), 8'(i % 3), 1'b0, 1'b0, 1'b0, 1'b0);
            tick();
        end
        drive(1'b1, mk(7, 7, 7), 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("full.fifo_count", 32'(fifo_count), 16);
        check("full.push_ready", 32'(push_ready), 0);
        tick();
        drive(1'b0, '0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("drop17.fifo_count", 32'(fifo_count), 16);
        tick();
        drive(1'b1, mk(7, 7, 7), 8'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("fullpp.push_ready", 32'(push_ready), 0);
        check("fullpp.cu_inst", 32'(cu_inst), 32'(mk(2, 0, 0)));
        tick();
        idle_drive();
        check("fullpp.fifo_count", 32'(fifo_count), 15);
        check_model("fullpp");

        // Head now has rep 1: issue once, then hold cu_flag low for 5 cycles
        drive(1'b0, '0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        idle_drive();
        saved = cu_inst;
        check("hold.advanced", 32'(saved), 32'(mk(2, 2, 3)));
        for (int i = 0; i < 5; i++) begin
            idle_drive();
            check("hold.cu_inst", 32'(cu_inst), 32'(saved));
            check("hold.fifo_count", 32'(fifo_count), 15);
            tick();
        end
        drive(1'b0, '0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        idle_drive();
        check("hold.resume_pop", 32'(fifo_count), 14);
        check_model("hold");

        // Abort with 4 queued entries in RUN, plus a push and start in the abort cycle
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, mk(4, i, i), 8'd1, 1'b0, 1'b0, 1'b0, 1'b0);
            tick();
        end
        drive(1'b0, '0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b1, mk(5, 1, 1), 8'd0, 1'b1, 1'b1, 1'b1, 1'b0);
        check("abort.pre_busy", 32'(busy), 1);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, '0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0);
            check("abort.fifo_count", 32'(fifo_count), 0);
            check("abort.cu_inst", 32'(cu_inst), 32'(IDLE_INST));
            check("abort.busy", 32'(busy), 0);
            check("abort.done", 32'(done), 0);
            tick();
        end

        // Reset mid-RUN with start, push and cu_flag high
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, mk(6, i, i), 8'd2, 1'b0, 1'b0, 1'b0, 1'b0);
            tick();
        end
        drive(1'b0, '0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b0, '0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        drive(1'b1, mk(6, 9, 9), 8'd0, 1'b1, 1'b0, 1'b1, 1'b1);
        tick();
        drive(1'b0, '0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("rstrun.cu_inst", 32'(cu_inst), 32'(IDLE_INST));
        check("rstrun.push_ready", 32'(push_ready), 1);
        check("rstrun.busy", 32'(busy), 0);
        check("rstrun.done", 32'(done), 0);
        check("rstrun.fifo_count", 32'(fifo_count), 0);
        tick();
        idle_drive();
        check("rstrun.still_idle", 32'(busy), 0);
        check("rstrun.no_done", 32'(done), 0);
        tick();

        // Randomized traffic against the reference model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            drive(1'($urandom_range(0, 99) < 55), INST_BITS'($urandom), 8'($urandom_range(0, 3)),
                  1'($urandom_range(0, 99) < 10), 1'($urandom_range(0, 99) < 2),
                  1'($urandom_range(0, 99) < 60), 1'($urandom_range(0, 999) < 5));
            check_model("rand");
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
